// File: rtl/crc8_stream_checker.sv
// Multi-lane CRC-8 frame checker: LANES bytes per beat, last valid byte of a frame is the received CRC.
// Reports computed CRC and match once per frame, with frame/error counters.
module crc8_stream_checker #(
  parameter int          LANES = 4,
  parameter logic [7:0]  POLY  = 8'h07,
  parameter logic [7:0]  INIT  = 8'h00,
  parameter int          CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_last,
  input  logic [2:0]           i_nbytes,
  input  logic [8*LANES-1:0]   i_data,
  output logic                 o_done,
  output logic                 o_match,
  output logic [7:0]           o_crc8,
  output logic [CNT_W-1:0]     o_frame_count,
  output logic [CNT_W-1:0]     o_err_count
);

  localparam logic [2:0] LANES_W = 3'(LANES);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESULT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       crcOut_q, crcOut_d;
  logic             match_q, match_d;
  logic             armed_q;
  logic [CNT_W-1:0] frameCount_q, frameCount_d;
  logic [CNT_W-1:0] errCount_q, errCount_d;

  logic [7:0]       laneByte [LANES];
  logic [7:0]       tap [LANES+1];
  logic [2:0]       nbEff;
  logic [7:0]       frameTap;
  logic [7:0]       rxByte;
  logic             accept;

  function automatic logic [7:0] crcByte(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) begin
      r = r[7] ? ((r << 1) ^ POLY) : (r << 1);
    end
    return r;
  endfunction

  // tap[i] is the CRC after the first i lanes; the frame CRC is the tap just before the CRC lane.
  always_comb begin
    tap[0] = crc_q;
    for (int i = 0; i < LANES; i++) begin
      laneByte[i] = i_data[8*i +: 8];
      tap[i+1]    = crcByte(tap[i], laneByte[i]);
    end
    nbEff    = ((i_nbytes == 3'd0) || (i_nbytes > LANES_W)) ? LANES_W : i_nbytes;
    frameTap = tap[0];
    rxByte   = laneByte[0];
    for (int i = 0; i < LANES; i++) begin
      if (nbEff == 3'(i + 1)) begin
        frameTap = tap[i];
        rxByte   = laneByte[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    crcOut_d     = crcOut_q;
    match_d      = match_q;
    frameCount_d = frameCount_q;
    errCount_d   = errCount_q;
    o_done       = 1'b0;
    o_ready      = armed_q && (state_q != RESULT);
    accept       = i_valid && o_ready;

    case (state_q)
      IDLE, BUSY: begin
        if (accept) begin
          if (i_last) begin
            state_d  = RESULT;
            crc_d    = frameTap;
            crcOut_d = frameTap;
            match_d  = (frameTap == rxByte);
          end else begin
            state_d  = BUSY;
            crc_d    = tap[LANES];
          end
        end
      end
      RESULT: begin
        o_done       = 1'b1;
        state_d      = IDLE;
        crc_d        = INIT;
        frameCount_d = frameCount_q + CNT_W'(1);
        if (!match_q && (errCount_q != '1)) begin
          errCount_d = errCount_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // armed_q holds o_ready low until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      crc_q        <= INIT;
      crcOut_q     <= 8'h00;
      match_q      <= 1'b0;
      armed_q      <= 1'b0;
      frameCount_q <= '0;
      errCount_q   <= '0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      crcOut_q     <= crcOut_d;
      match_q      <= match_d;
      armed_q      <= 1'b1;
      frameCount_q <= frameCount_d;
      errCount_q   <= errCount_d;
    end
  end

  assign o_match       = match_q;
  assign o_crc8        = crcOut_q;
  assign o_frame_count = frameCount_q;
  assign o_err_count   = errCount_q;

endmodule
